// File: rtl/rr_stream_arbiter_pkg.sv
// rr_stream_arbiter_pkg: shared state encoding and pointer sizing for the round-robin stream arbiter.
package rr_stream_arbiter_pkg;
  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE   = 1'b0;
  localparam arb_state_t LOCKED = 1'b1;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_oh.sv
// MuxOH: one-hot select data mux; an all-zero select yields zero.
module MuxOH #(
  parameter int InputWidth = 4,
  parameter int DataWidth  = 32
) (
  input  logic [InputWidth-1:0]           sel_i,
  input  logic [InputWidth*DataWidth-1:0] data_i,
  output logic [DataWidth-1:0]            data_o
);
  always_comb begin
    data_o = '0;
    for (int i = 0; i < InputWidth; i++)
      data_o = data_o | (data_i[i*DataWidth +: DataWidth] & {DataWidth{sel_i[i]}});
  end
endmodule

// File: rtl/rr_pick_oh.sv
// rr_pick_oh: combinational round-robin one-hot picker; lowest request at or above ptr, else lowest overall.
module rr_pick_oh
  import rr_stream_arbiter_pkg::*;
#(
  parameter int InputWidth = 4
) (
  input  logic [InputWidth-1:0]             req,
  input  logic [ptr_w(InputWidth)-1:0]      ptr,
  output logic [InputWidth-1:0]             gnt
);
  logic [InputWidth-1:0] masked;
  assign masked = req & ({InputWidth{1'b1}} << ptr);
  assign gnt = |masked ? (masked & (~masked + InputWidth'(1)))
                       : (req & (~req + InputWidth'(1)));
endmodule

// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin packet arbiter; holds the grant from first presented beat until the last beat is accepted.
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter int InputWidth = 4,
  parameter int DataWidth  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [InputWidth-1:0]           valid_i,
  input  logic [InputWidth-1:0]           last_i,
  input  logic [InputWidth*DataWidth-1:0] data_i,
  output logic [InputWidth-1:0]           ready_o,
  output logic                            valid_o,
  output logic                            last_o,
  output logic [DataWidth-1:0]            data_o,
  input  logic                            ready_i,
  output logic [InputWidth-1:0]           gnt_oh_o
);
  localparam int PW = ptr_w(InputWidth);
  arb_state_t            st_q;
  logic [PW-1:0]         ptr_q, win_idx, ptr_nxt;
  logic [InputWidth-1:0] gnt_q, pick;
  logic                  fire;
  rr_pick_oh #(.InputWidth(InputWidth)) u_pick (
    .req(valid_i),
    .ptr(ptr_q),
    .gnt(pick)
  );
  MuxOH #(.InputWidth(InputWidth), .DataWidth(DataWidth)) u_mux (
    .sel_i(gnt_oh_o),
    .data_i(data_i),
    .data_o(data_o)
  );
  assign gnt_oh_o = (st_q == LOCKED) ? gnt_q : pick;
  assign valid_o  = |(valid_i & gnt_oh_o);
  assign last_o   = |(last_i & gnt_oh_o);
  assign ready_o  = gnt_oh_o & {InputWidth{ready_i}};
  assign fire     = valid_o & ready_i;
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < InputWidth; i++)
      if (gnt_oh_o[i]) win_idx = PW'(i);
  end
  // non-power-of-two widths need an explicit wrap
  assign ptr_nxt = (win_idx == PW'(InputWidth - 1)) ? '0 : win_idx + PW'(1);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q  <= IDLE;
      ptr_q <= '0;
      gnt_q <= '0;
    end else if (fire && last_o) begin
      st_q  <= IDLE;
      ptr_q <= ptr_nxt;
      gnt_q <= '0;
    end else if (st_q == IDLE && valid_o) begin
      st_q  <= LOCKED;
      gnt_q <= gnt_oh_o;
    end
  end
endmodule
